// File: rtl/clk_div_n_if.sv
// Control/status bundle for clk_div_n: run enable, divisor load, divided clock and strobes.
interface clk_div_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             cout;
    logic             tick;
    logic [WIDTH-1:0] div_cur;
    logic             err;

    modport master (
        output en, div_in, div_load,
        input  cout, tick, div_cur, err
    );

    modport slave (
        input  en, div_in, div_load,
        output cout, tick, div_cur, err
    );
endinterface

// File: rtl/clk_div_n.sv
// Programmable 50%-duty integer clock divider; odd divisors borrow a half cycle from a
// negedge helper flop. New divisors are applied only at a period boundary.
module clk_div_n #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 7
) (
    input  logic         clk,
    input  logic         res,
    clk_div_n_if.slave   ctrl_io
);
    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] div_cur_q, div_cur_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    logic             pend_v_q, pend_v_d;
    logic             pos_q, pos_d;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             run_q, run_d;
    logic             live_q, live_d;
    logic             neg_q;

    logic             wrap;
    logic             apply;
    logic [WIDTH-1:0] n_next;

    always_comb begin
        m_d       = m_q;
        div_cur_d = div_cur_q;
        pending_d = pending_q;
        pend_v_d  = pend_v_q;
        pos_d     = pos_q;
        run_d     = run_q;
        tick_d    = 1'b0;
        live_d    = 1'b1;
        err_d     = ctrl_io.div_load && (ctrl_io.div_in < WIDTH'(2));

        // run_q distinguishes the very first counting edge, which enters phase 0 directly
        wrap   = run_q && (m_q == div_cur_q - WIDTH'(1));
        apply  = ctrl_io.en && wrap && pend_v_q;
        n_next = apply ? pending_q : div_cur_q;

        if (ctrl_io.en) begin
            run_d = 1'b1;
            m_d   = (!run_q || wrap) ? '0 : m_q + WIDTH'(1);
            if (apply) begin
                div_cur_d = pending_q;
                pend_v_d  = 1'b0;
            end
            pos_d  = m_d < (n_next >> 1);
            tick_d = (m_d == '0);
        end

        // A load on the wrap edge lands after the apply, so it waits for the next wrap
        if (ctrl_io.div_load && (ctrl_io.div_in >= WIDTH'(2))) begin
            pending_d = ctrl_io.div_in;
            pend_v_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            m_q       <= '0;
            div_cur_q <= DefDiv;
            pending_q <= DefDiv;
            pend_v_q  <= 1'b0;
            pos_q     <= 1'b0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
            live_q    <= 1'b0;
        end else begin
            m_q       <= m_d;
            div_cur_q <= div_cur_d;
            pending_q <= pending_d;
            pend_v_q  <= pend_v_d;
            pos_q     <= pos_d;
            tick_q    <= tick_d;
            err_q     <= err_d;
            run_q     <= run_d;
            live_q    <= live_d;
        end
    end

    always_ff @(negedge clk) begin
        if (!res) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // live_q masks a stale neg_q so cout drops on the reset posedge itself
    assign ctrl_io.cout    = pos_q | (div_cur_q[0] & live_q & neg_q);
    assign ctrl_io.tick    = tick_q;
    assign ctrl_io.div_cur = div_cur_q;
    assign ctrl_io.err     = err_q;
endmodule

// File: tb/tb_clk_div_n.sv
// Self-checking bench for clk_div_n: directed plan steps then random traffic, checked
// against a half-cycle waveform model (cout high for the first N of every 2N half cycles).
module tb_clk_div_n;
    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic res = 1'b0;

    clk_div_n_if #(.WIDTH(W)) bus ();

    clk_div_n #(.WIDTH(W), .DEFAULT_DIV(7)) dut (
        .clk     (clk),
        .res     (res),
        .ctrl_io (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_started;
    bit m_frozen;
    int m_k;
    int m_n;
    int m_pend;
    bit m_pv;
    bit m_tick;
    bit m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_cout(input int half);
        int j;
        if (!m_started) return 0;
        j = m_frozen ? 2 * m_k + 1 : 2 * m_k + half;
        return (j < m_n) ? 1 : 0;
    endfunction

    task automatic model_edge();
        bit ld_ok;
        if (!res) begin
            m_started = 0; m_frozen = 0; m_k = 0; m_n = 7; m_pend = 7; m_pv = 0;
            m_tick = 0; m_err = 0;
            return;
        end
        m_err = bus.div_load && (int'(bus.div_in) < 2);
        ld_ok = bus.div_load && (int'(bus.div_in) >= 2);
        if (bus.en) begin
            m_frozen = 0;
            if (!m_started) begin
                m_started = 1;
                m_k = 0;
            end else if (m_k == m_n - 1) begin
                m_k = 0;
                if (m_pv) begin
                    m_n = m_pend;
                    m_pv = 0;
                end
            end else begin
                m_k++;
            end
            m_tick = (m_k == 0);
        end else begin
            m_frozen = m_started;
            m_tick = 0;
        end
        if (ld_ok) begin
            m_pend = int'(bus.div_in);
            m_pv = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cout_hi_half", 32'(bus.cout), 32'(exp_cout(0)));
        chk("tick", 32'(bus.tick), 32'(m_tick));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("div_cur", 32'(bus.div_cur), 32'(m_n));
        @(negedge clk);
        #1;
        chk("cout_lo_half", 32'(bus.cout), 32'(exp_cout(1)));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int d);
        bus.div_load = 1'b1;
        bus.div_in   = W'(d);
        step();
        bus.div_load = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 300 && m_k != ph; i++) step();
        if (m_k != ph) begin
            errors++;
            $error("FAIL wait_phase: got phase %0d expected %0d", m_k, ph);
        end
    endtask

    initial begin
        m_started = 0; m_frozen = 0; m_k = 0; m_n = 7; m_pend = 7; m_pv = 0;
        m_tick = 0; m_err = 0;
        bus.en = 1'b0; bus.div_load = 1'b0; bus.div_in = '0;

        // Reset, then default N=7
        run(3);
        res = 1'b1; bus.en = 1'b1;
        run(28);

        // Even N=4
        load(4);
        run(14);

        // Boundaries N=2 then N=3
        load(2);
        run(8);
        load(3);
        run(9);

        // Mid-period load during phase 2 of N=7
        load(7);
        run(10);
        wait_phase(2);
        load(5);
        run(14);

        // Load exactly on the wrap edge
        wait_phase(m_n - 1);
        load(6);
        run(20);

        // Rejected loads
        load(1);
        load(0);
        run(8);

        // Freeze in phase 1
        wait_phase(1);
        bus.en = 1'b0;
        run(5);
        bus.en = 1'b1;
        run(10);

        // Reset in phase 2 with a load pending
        wait_phase(2);
        load(4);
        res = 1'b0;
        run(2);
        res = 1'b1;
        run(16);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            res          = ($urandom_range(99) != 0);
            bus.en       = ($urandom_range(7) != 0);
            bus.div_load = ($urandom_range(5) == 0);
            bus.div_in   = W'($urandom_range(11));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
